// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access width codes,
// default memory capacity and FSM state encodings.
package dmem_arbiter_pkg;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF      = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;
    localparam logic [1:0] ILLEGAL_W = 2'b11;

    localparam int DATA_MEM_SIZE = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Number of bytes touched by an access of the given width code.
    // The illegal code is reported as 4 so the range check stays conservative.
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            BYTE:    width_bytes = 3'd1;
            HALF:    width_bytes = 3'd2;
            default: width_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin select: on a tie the port not granted last wins,
// otherwise the sole requester wins.
module dmem_rr_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    assign o_valid = i_req0 | i_req1;
    assign o_grant = (i_req0 & i_req1) ? ~i_last_grant : i_req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the core LSU (port 0) and the debug/loader (port 1) onto a
// single data memory. Each transaction is IDLE -> ACCESS -> RESP; illegal
// commands skip ACCESS and answer with err and no memory strobe.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = DATA_MEM_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [1:0]            width0,
    input  logic [1:0]            width1,
    input  logic                  sext0,
    input  logic                  sext1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [31:0]           wdata0,
    input  logic [31:0]           wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic                  SignExtend,
    output logic [1:0]            MemWidth,
    output logic [ADDR_WIDTH-1:0] WriteAddress,
    output logic [ADDR_WIDTH-1:0] Address1,
    output logic [31:0]           WriteData,
    input  logic [31:0]           ReadData1
);

    // One extra bit so addr + bytes cannot wrap before the range compare.
    localparam int AW1 = ADDR_WIDTH + 1;

    state_e                r_state;
    state_e                w_next;
    logic                  r_last_grant;
    logic                  r_grant;
    logic                  r_we;
    logic [1:0]            r_width;
    logic                  r_sext;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_err;
    logic [31:0]           r_rdata;

    logic                  w_valid;
    logic                  w_pick;
    logic                  w_we;
    logic [1:0]            w_width;
    logic                  w_sext;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_wdata;
    logic [AW1-1:0]        w_end;
    logic                  w_misaligned;
    logic                  w_illegal;
    logic                  w_latch;

    dmem_rr_pick u_pick (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_grant (r_last_grant),
        .o_valid      (w_valid),
        .o_grant      (w_pick)
    );

    // Winner's command, selected ahead of the latch.
    assign w_we    = w_pick ? we1    : we0;
    assign w_width = w_pick ? width1 : width0;
    assign w_sext  = w_pick ? sext1  : sext0;
    assign w_addr  = w_pick ? addr1  : addr0;
    assign w_wdata = w_pick ? wdata1 : wdata0;

    assign w_end        = {1'b0, w_addr} + AW1'(width_bytes(w_width));
    assign w_misaligned = ((w_width == HALF) && w_addr[0]) ||
                          ((w_width == WORD) && (w_addr[1:0] != 2'b00));
    assign w_illegal    = (w_width == ILLEGAL_W) || w_misaligned ||
                          (w_end > AW1'(MEM_SIZE));

    assign w_latch = (r_state == IDLE) && w_valid;

    assign err   = r_err;
    assign rdata = r_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state: illegal commands jump straight to RESP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = w_illegal ? RESP : ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Memory strobes only in ACCESS; ack only in RESP, masked by reset so a
    // reset landing in RESP never shows an ack.
    always_comb begin
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        SignExtend   = 1'b0;
        MemWidth     = 2'b00;
        WriteAddress = '0;
        Address1     = '0;
        WriteData    = '0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        case (r_state)
            ACCESS: begin
                MemWrite     = r_we;
                MemRead      = ~r_we;
                SignExtend   = r_sext;
                MemWidth     = r_width;
                WriteAddress = r_addr;
                Address1     = r_addr;
                WriteData    = r_wdata;
            end
            RESP: begin
                ack0 = ~reset & ~r_grant;
                ack1 = ~reset &  r_grant;
            end
            default: ;
        endcase
    end

    // Command latch at grant time and read-data capture at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_width      <= 2'b00;
            r_sext       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_latch) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_we         <= w_we;
                r_width      <= w_width;
                r_sext       <= w_sext;
                r_addr       <= w_addr;
                r_wdata      <= w_wdata;
                r_err        <= w_illegal;
                r_rdata      <= '0;
            end
            if (r_state == ACCESS) r_rdata <= r_we ? 32'h0 : ReadData1;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of all address ports.
REQ-002 SHALL have parameter MEM_SIZE, default `DATA_MEM_SIZE: byte capacity of the attached data memory.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports req0 / req1, input, 1 each: request from port 0 (core LSU) and port 1 (debug/loader).
REQ-006 SHALL have ports we0 / we1, input, 1 each: 1 = store, 0 = load.
REQ-007 SHALL have ports width0 / width1, input, 2 each: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have ports sext0 / sext1, input, 1 each: sign-extend the load result.
REQ-009 SHALL have ports addr0 / addr1, input, ADDR_WIDTH each: byte address.
REQ-010 SHALL have ports wdata0 / wdata1, input, 32 each: store data.
REQ-011 SHALL have ports ack0 / ack1, output, 1 each: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1: valid with the ack; 1 = rejected, no memory access performed.
REQ-013 SHALL have port rdata, output, 32: load data, valid with the ack.
REQ-014 SHALL have ports MemWrite, MemRead, SignExtend, outputs, 1 each, plus MemWidth, output, 2: memory strobes and controls.
REQ-015 SHALL have ports WriteAddress and Address1, outputs, ADDR_WIDTH each, plus WriteData, output, 32: memory address and data.
REQ-016 SHALL have port ReadData1, input, 32: asynchronous read data from the memory.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-018 IDLE: at the posedge with any reqN=1, SHALL latch the winner's we/width/sext/addr/wdata into the command registers and record the winner.
REQ-019 Tie (req0 = req1 = 1): SHALL grant the port that was not granted last; the last_grant register SHALL reset to 1, so port 0 wins the first tie.
REQ-020 After latching: a legal command SHALL move to ACCESS; an illegal command SHALL move directly to RESP with err=1.
REQ-021 SHALL treat a command as illegal when:
  - width = 11;
  - half with addr[0] != 0;
  - word with addr[1:0] != 00;
  - addr + bytes > MEM_SIZE (bytes = 1/2/4), computed at ADDR_WIDTH+1 bits so it cannot wrap.
REQ-022 ACCESS (exactly 1 cycle):
  - SHALL drive MemWrite = we and MemRead = !we;
  - SHALL drive MemWidth, SignExtend, WriteAddress = Address1 = addr and WriteData from the command registers;
  - the memory commits the store on the negedge within this cycle.
REQ-023 ACCESS: at the closing posedge, SHALL capture ReadData1 into rdata for a load (rdata = 0 for a store) and move to RESP.
REQ-024 RESP (exactly 1 cycle): SHALL assert ack of the granted port; other outputs SHALL hold; then return to IDLE.
REQ-025 Outside ACCESS: SHALL hold MemWrite = MemRead = 0 and address/data/controls at 0.
REQ-026 Handshake: a requester SHALL hold reqN and its command stable until it sees ackN, then drop reqN in the next cycle.
REQ-027 Signals sampled in ACCESS or RESP SHALL be ignored.
REQ-028 Latency: from req sampled in IDLE (cycle N) to ack in cycle N+2; throughput is one transaction per 3 cycles.
REQ-029 Error: from req sampled (cycle N) to ack with err in cycle N+1; no strobe SHALL be asserted.
REQ-030 A losing requester SHALL keep its request pending and SHALL be granted at the next IDLE.

Reset
REQ-031 With reset high at a posedge:
  - state SHALL go to IDLE, with last_grant = 1;
  - ack0 = ack1 = err = 0 and rdata = 0;
  - all memory-side outputs = 0.
REQ-032 Reset during ACCESS SHALL abort the transaction with no ack; a store strobed in that cycle still completes at the negedge.
REQ-033 Reset during RESP SHALL suppress the ack.

Structure
REQ-034 The shared package / mips_defines.vh SHALL hold the width codes (BYTE/HALF/WORD), DATA_MEM_SIZE, and the FSM state encodings.
REQ-035 SHALL contain one sub-module, dmem_rr_pick: combinational two-way round-robin select from (req0, req1, last_grant).

Verification
REQ-036 Store: req0 sw addr 0x10 wdata 0xDEADBEEF -> MemWrite high for 1 cycle; ack0 at N+2 with err = 0; then a req1 lw at 0x10 -> rdata 0xDEADBEEF.
REQ-037 Sign-extended load: a byte 0x80 at 0x21, req0 lb sext = 1 -> rdata 0xFFFFFF80; with sext = 0 -> 0x00000080.
REQ-038 Tie: req0 and req1 held together for 4 transactions -> grants 0,1,0,1; each ack arrives 3 cycles apart.
REQ-039 Illegal commands: lw at 0x13 -> ack at N+1 with err = 1 and no MemRead/MemWrite; sw at MEM_SIZE-2 -> err = 1; width 11 -> err = 1.
REQ-040 Reset mid-operation: reset asserted in RESP -> no ack; IDLE next cycle; a subsequent req0 completes normally.
